sram_port_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port SRAM macro (csb0/web0/addr0/din0/dout0) used by the UPDI application layer. It lets the UPDI write path (port 0) and the memory read-out path (port 1) share the one SRAM port. Each port gets per-access grant/accept handshaking, round-robin fairness, optional burst locking with a timeout, and read data returned at a fixed latency.

---
 rtl/sram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin two-port sequencer onto a single-port SRAM, with burst lock and forced release on timeout.
// Grant is combinational; SRAM command registered at accept; read data and rvalid two edges after accept.
module sram_port_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_p0_req,
  input  logic                  i_p0_we,
  input  logic                  i_p0_lock,
  input  logic [ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [DATA_WIDTH-1:0] i_p0_wdata,
  input  logic                  i_p1_req,
  input  logic                  i_p1_we,
  input  logic                  i_p1_lock,
  input  logic [ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [DATA_WIDTH-1:0] i_p1_wdata,
  output logic                  o_p0_gnt,
  output logic                  o_p1_gnt,
  output logic                  o_p0_rvalid,
  output logic                  o_p1_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_lock_err,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  logic          locked;
  logic          owner;
  logic          last_grant;
  logic [TW-1:0] tcnt;
  logic [1:0]    rd_s1;  // {read_valid, port}
  logic [1:0]    rd_s2;

  logic                  owner_lock;
  logic                  eff_lock;
  logic                  nonowner_req;
  logic                  timeout_hit;
  logic                  acc;
  logic                  acc_port;
  logic                  acc_we;
  logic                  acc_lock;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  // A lock only blocks the other port while the owner keeps its lock input high,
  // so the waiting port can be granted in the very cycle the lock drops.
  always_comb begin
    owner_lock   = owner ? i_p1_lock : i_p0_lock;
    eff_lock     = locked & owner_lock;
    nonowner_req = owner ? i_p0_req : i_p1_req;
    o_p0_gnt     = 1'b0;
    o_p1_gnt     = 1'b0;
    if (eff_lock) begin
      o_p0_gnt = ~owner & i_p0_req;
      o_p1_gnt = owner & i_p1_req;
    end else if (i_p0_req & i_p1_req) begin
      o_p0_gnt = last_grant;
      o_p1_gnt = ~last_grant;
    end else begin
      o_p0_gnt = i_p0_req;
      o_p1_gnt = i_p1_req;
    end
  end

  always_comb begin
    timeout_hit = (LOCK_TIMEOUT != 0) && eff_lock && (tcnt == TW'(LOCK_TIMEOUT));
    acc         = o_p0_gnt | o_p1_gnt;
    acc_port    = o_p1_gnt;
    acc_we      = o_p1_gnt ? i_p1_we    : i_p0_we;
    acc_lock    = o_p1_gnt ? i_p1_lock  : i_p0_lock;
    acc_addr    = o_p1_gnt ? i_p1_addr  : i_p0_addr;
    acc_wdata   = o_p1_gnt ? i_p1_wdata : i_p0_wdata;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      locked     <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      tcnt       <= '0;
      o_lock_err <= 1'b0;
    end else if (timeout_hit) begin
      // Forced release hands the next tie to the starved port.
      locked     <= 1'b0;
      tcnt       <= '0;
      last_grant <= owner;
      o_lock_err <= 1'b1;
    end else begin
      o_lock_err <= 1'b0;
      if (acc) last_grant <= acc_port;
      if (acc && acc_lock) begin
        locked <= 1'b1;
        owner  <= acc_port;
      end else if (locked && !owner_lock) begin
        locked <= 1'b0;
      end
      if ((LOCK_TIMEOUT != 0) && eff_lock && nonowner_req) tcnt <= tcnt + 1'b1;
      else tcnt <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
    end else begin
      csb0 <= ~acc;
      web0 <= ~(acc & acc_we);
      if (acc) begin
        addr0 <= acc_addr;
        din0  <= acc_wdata;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_s1       <= '0;
      rd_s2       <= '0;
      o_p0_rvalid <= 1'b0;
      o_p1_rvalid <= 1'b0;
      o_rdata     <= '0;
    end else begin
      rd_s1       <= {acc & ~acc_we, acc_port};
      rd_s2       <= rd_s1;
      o_p0_rvalid <= rd_s2[1] & ~rd_s2[0];
      o_p1_rvalid <= rd_s2[1] & rd_s2[0];
      if (rd_s2[1]) o_rdata <= dout0;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_sram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 8;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [1:0]    lock = '0;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];

  logic          o_p0_gnt, o_p1_gnt, o_p0_rvalid, o_p1_rvalid, o_lock_err;
  logic [DW-1:0] o_rdata;
  logic          csb0, web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;

  sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_p0_req(req[0]), .i_p0_we(we[0]), .i_p0_lock(lock[0]), .i_p0_addr(addr[0]), .i_p0_wdata(wdata[0]),
    .i_p1_req(req[1]), .i_p1_we(we[1]), .i_p1_lock(lock[1]), .i_p1_addr(addr[1]), .i_p1_wdata(wdata[1]),
    .o_p0_gnt(o_p0_gnt), .o_p1_gnt(o_p1_gnt), .o_p0_rvalid(o_p0_rvalid), .o_p1_rvalid(o_p1_rvalid),
    .o_rdata(o_rdata), .o_lock_err(o_lock_err),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  always #5 i_clk = ~i_clk;

  // SRAM macro behaviour: command sampled at the rising edge, read data valid afterwards.
  logic [DW-1:0] mem [256];
  always @(posedge i_clk) begin
    if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else dout0 <= mem[addr0];
    end
  end

  // Reference model state
  typedef struct { int port; logic [DW-1:0] data; int due; } rd_t;
  rd_t           rq[$];
  logic [DW-1:0] shadow [256];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            m_locked;
  int            m_owner, m_last, m_wait;
  bit            e_csb, e_web, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, e_rdata;
  logic [1:0]    e_rv;
  logic [1:0]    acc_flags = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (m_locked && lock[m_owner]) return req[m_owner] ? m_owner : -1;
    if (req[0] && req[1]) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_last = 1; m_wait = 0;
    rq.delete();
    e_csb = 1; e_web = 1; e_err = 0; e_addr = '0; e_din = '0; e_rdata = '0; e_rv = '0;
  endtask

  // One clock: check at negedge, advance model at posedge, return just after the edge.
  task automatic tick();
    int g;
    bit own_lk;
    @(negedge i_clk);
    g = exp_grant();
    chk("gnt0", o_p0_gnt, g == 0);
    chk("gnt1", o_p1_gnt, g == 1);
    chk("csb0", csb0, e_csb);
    chk("web0", web0, e_web);
    chk("addr0", addr0, e_addr);
    chk("din0", din0, e_din);
    chk("rvalid", {o_p1_rvalid, o_p0_rvalid}, e_rv);
    chk("rdata", o_rdata, e_rdata);
    chk("lock_err", o_lock_err, e_err);
    @(posedge i_clk);
    cyc++;
    acc_flags = '0;
    e_rv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv[rq[0].port] = 1'b1;
      e_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    if (g >= 0) begin
      acc_flags[g] = 1'b1;
      e_csb = 0; e_web = !we[g]; e_addr = addr[g]; e_din = wdata[g];
      if (we[g]) shadow[addr[g]] = wdata[g];
      else rq.push_back('{g, shadow[addr[g]], cyc + 2});
    end else begin
      e_csb = 1; e_web = 1;
    end
    own_lk = m_locked && lock[m_owner];
    if (own_lk && m_wait == TO) begin
      m_locked = 0; m_wait = 0; m_last = m_owner; e_err = 1;
    end else begin
      e_err = 0;
      if (g >= 0) m_last = g;
      m_wait = (own_lk && req[1 - m_owner]) ? m_wait + 1 : 0;
      if (g >= 0 && lock[g]) begin
        m_locked = 1; m_owner = g;
      end else if (m_locked && !lock[m_owner]) begin
        m_locked = 0;
      end
    end
    #1;
  endtask

  // Called just after a rising edge; asserts reset mid-cycle and holds it over one edge.
  task automatic mid_reset();
    #2;
    i_reset = 1'b1;
    #1;
    chk("rst_csb0", csb0, 1);
    chk("rst_web0", web0, 1);
    chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_rvalid", {o_p1_rvalid, o_p0_rvalid}, 0);
    chk("rst_lock_err", o_lock_err, 0);
    model_reset();
    req = '0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = r; we[p] = w; lock[p] = l; addr[p] = a; wdata[p] = d;
  endtask

  initial begin
    int  waits;
    bit  got_err;
    bit  did_rst;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    mem[5] = 8'h2A;
    shadow[5] = 8'h2A;
    #1;
    mid_reset();

    // Single read by p1
    set_port(1, 1, 0, 0, 8'h05, 8'h00);
    tick();
    chk("single_acc", acc_flags, 2'b10);
    chk("single_csb0", csb0, 0);
    chk("single_web0", web0, 1);
    chk("single_addr0", addr0, 8'h05);
    req = '0;
    tick();
    tick();
    chk("single_rvalid", o_p1_rvalid, 1);
    chk("single_rdata", o_rdata, 8'h2A);
    repeat (2) tick();

    // Contention: strict alternation starting with p0
    set_port(0, 1, 0, 0, 8'h20, 8'h00);
    set_port(1, 1, 0, 0, 8'h30, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("cont_gnt", acc_flags, (i % 2 == 0) ? 2'b01 : 2'b10);
      for (int p = 0; p < 2; p++) if (acc_flags[p]) addr[p] = addr[p] + 8'd1;
    end
    req = '0;
    repeat (4) tick();

    // Locked burst by p0 with p1 waiting
    set_port(1, 1, 0, 0, 8'h40, 8'h00);
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1, 1, 1, 8'(i), 8'(8'h10 + i));
      tick();
      chk("burst_p0", acc_flags, 2'b01);
    end
    set_port(0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    chk("burst_release", acc_flags, 2'b10);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1, 0, 0, 8'(i), 8'h00);
      tick();
    end
    req = '0;
    repeat (4) tick();

    // Lock timeout
    set_port(0, 1, 1, 1, 8'h50, 8'h77);
    tick();
    set_port(0, 0, 0, 1, 8'h00, 8'h00);
    set_port(1, 1, 0, 0, 8'h50, 8'h00);
    waits = 0;
    got_err = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_lock_err) begin
        got_err = 1;
        break;
      end
      waits++;
    end
    chk("to_err_seen", got_err, 1);
    chk("to_waits", waits, TO);
    tick();
    chk("to_p1_gnt", acc_flags, 2'b10);
    chk("to_err_pulse", o_lock_err, 0);
    req[1] = 1'b0;
    set_port(0, 1, 1, 1, 8'h51, 8'h88);
    tick();
    chk("relock", acc_flags, 2'b01);
    set_port(0, 0, 0, 1, 8'h00, 8'h00);
    set_port(1, 1, 0, 0, 8'h51, 8'h00);
    tick();
    chk("relock_block", acc_flags, 2'b00);
    lock[0] = 1'b0;
    tick();
    chk("relock_release", acc_flags, 2'b10);
    req = '0;
    lock = '0;
    repeat (4) tick();

    // Reset with a read in flight
    set_port(0, 1, 0, 0, 8'h05, 8'h00);
    tick();
    chk("rstrd_acc", acc_flags, 2'b01);
    mid_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstrd_no_rvalid", o_p0_rvalid, 0);
    end
    set_port(0, 1, 0, 0, 8'h05, 8'h00);
    tick();
    req = '0;
    tick();
    tick();
    chk("rstrd_rvalid", o_p0_rvalid, 1);
    chk("rstrd_rdata", o_rdata, 8'h2A);
    repeat (2) tick();

    // Random mixed traffic
    did_rst = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!did_rst && c >= 700 && e_web) begin
        mid_reset();
        did_rst = 1;
      end
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || acc_flags[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            req[p] = 1'b1;
            we[p] = 1'($urandom_range(0, 1));
            addr[p] = 8'($urandom_range(0, 15));
            wdata[p] = 8'($urandom);
            lock[p] = ($urandom_range(0, 3) == 0) || (lock[p] && $urandom_range(0, 3) != 0);
          end else begin
            req[p] = 1'b0;
            lock[p] = lock[p] && ($urandom_range(0, 3) != 0);
          end
        end
      end
      acc_flags = '0;
      tick();
    end
    req = '0;
    lock = '0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
